bsg_round_robin_dist_outputs_p2: RTL and testbench



---
 rtl/bsg_round_robin_dist_outputs_p2_pkg.sv | 15 +
 rtl/bsg_dist_fifo.sv | 63 ++++++
 rtl/bsg_round_robin_dist_outputs_p2.sv | 60 ++++++
 tb/tb_bsg_round_robin_dist_outputs_p2.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bsg_round_robin_dist_outputs_p2_pkg.sv
// Shared definitions for the two-output round-robin distributor.
//   num_channels_lp : number of output channels (fixed at 2)
//   chan_id_t       : channel index type (also the tag_o encoding)
//   other_chan()    : the channel that follows the given one in the rotation
package bsg_round_robin_dist_outputs_p2_pkg;

   localparam int num_channels_lp = 2;

   typedef logic chan_id_t;

   function automatic chan_id_t other_chan(input chan_id_t c);
      return ~c;
   endfunction

endpackage

// File: rtl/bsg_dist_fifo.sv
// Small registered FIFO used as one output buffer of the distributor.
//   clk_i, reset_i : clock, synchronous active-high reset
//   v_i, data_i    : push request and word (the push is dropped if full_o is set)
//   yumi_i         : pop request (the pop is dropped if empty_o is set)
//   data_o         : head word, meaningful only while empty_o = 0
//   full_o/empty_o : registered occupancy flags
module bsg_dist_fifo #(
   parameter int width_p = 32,
   parameter int els_p   = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   input  logic               yumi_i,
   output logic [width_p-1:0] data_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);

   localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
   localparam logic [cnt_w_lp-1:0] els_cnt_lp  = cnt_w_lp'(els_p);

   logic [width_p-1:0]  mem_r [els_p];
   logic [ptr_w_lp-1:0] wptr_r, rptr_r;
   logic [cnt_w_lp-1:0] count_r;
   logic                push, pop;

   assign full_o  = (count_r == els_cnt_lp);
   assign empty_o = (count_r == '0);
   assign push    = v_i & ~full_o;
   assign pop     = yumi_i & ~empty_o;
   assign data_o  = mem_r[rptr_r];

   // Depth need not be a power of two, so pointers wrap by compare-and-clear.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (push)
            wptr_r <= (wptr_r == last_ptr_lp) ? '0 : wptr_r + 1'b1;
         if (pop)
            rptr_r <= (rptr_r == last_ptr_lp) ? '0 : rptr_r + 1'b1;
         case ({push, pop})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked entirely by count_r.
   always_ff @(posedge clk_i) begin
      if (push)
         mem_r[wptr_r] <= data_i;
   end

endmodule

// File: rtl/bsg_round_robin_dist_outputs_p2.sv
// Round-robin distributor: consecutive accepted input words go strictly
// alternately to output channel 0 and channel 1, each buffered in a FIFO.
//   clk_i, reset_i : clock, synchronous active-high reset
//   v_i, data_i    : input word valid and word
//   ready_o        : input accepted this cycle when v_i & ready_o
//   v_o, data_o    : per-channel valid and head word (channel k at [k*width_p +: width_p])
//   yumi_i         : per-channel dequeue
//   tag_o          : channel that the next accepted word is steered to
module bsg_round_robin_dist_outputs_p2
   import bsg_round_robin_dist_outputs_p2_pkg::*;
#(
   parameter int width_p = 32,
   parameter int els_p   = 2
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic                                 v_i,
   input  logic [width_p-1:0]                   data_i,
   output logic                                 ready_o,
   output logic [num_channels_lp-1:0]           v_o,
   output logic [num_channels_lp*width_p-1:0]   data_o,
   input  logic [num_channels_lp-1:0]           yumi_i,
   output logic                                 tag_o
);

   chan_id_t                   ptr_r;
   logic [num_channels_lp-1:0] full, empty, push;

   // Only the pointed-to channel is eligible; the other channel's free space
   // is never used out of turn, which keeps the alternation exact.
   assign ready_o = ~reset_i & ~full[ptr_r];
   assign tag_o   = ptr_r;
   assign v_o     = ~empty;

   always_ff @(posedge clk_i) begin
      if (reset_i)
         ptr_r <= 1'b0;
      else if (v_i & ready_o)
         ptr_r <= other_chan(ptr_r);
   end

   for (genvar k = 0; k < num_channels_lp; k++) begin : g_chan
      assign push[k] = v_i & ready_o & (ptr_r == 1'(k));

      bsg_dist_fifo #(
         .width_p (width_p),
         .els_p   (els_p)
      ) u_fifo (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .v_i     (push[k]),
         .data_i  (data_i),
         .yumi_i  (yumi_i[k]),
         .data_o  (data_o[k*width_p +: width_p]),
         .full_o  (full[k]),
         .empty_o (empty[k])
      );
   end

endmodule

// File: tb/tb_bsg_round_robin_dist_outputs_p2.sv
module tb_bsg_round_robin_dist_outputs_p2;

   localparam int W   = 32;
   localparam int ELS = 3;

   logic           clk_i = 1'b0;
   logic           reset_i;
   logic           v_i;
   logic [W-1:0]   data_i;
   logic           ready_o;
   logic [1:0]     v_o;
   logic [2*W-1:0] data_o;
   logic [1:0]     yumi_i;
   logic           tag_o;

   bsg_round_robin_dist_outputs_p2 #(.width_p(W), .els_p(ELS)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (v_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .v_o     (v_o),
      .data_o  (data_o),
      .yumi_i  (yumi_i),
      .tag_o   (tag_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: one queue of expected words per channel and the
   // channel the next accepted word must go to.
   logic [W-1:0] exp_q [2][$];
   logic         mptr = 1'b0;
   int           acc_cnt = 0;
   int           checks = 0;
   int           failures = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Input-side monitor: compares the registered-state outputs with the model,
   // then applies this cycle's transfer or reset to the model.
   always @(negedge clk_i) begin
      logic exp_ready;
      exp_ready = !reset_i && (exp_q[mptr].size() < ELS);
      chk("ready_o", 64'(ready_o), 64'(exp_ready));
      chk("tag_o", 64'(tag_o), 64'(mptr));
      for (int k = 0; k < 2; k++) begin
         chk("v_o", 64'(v_o[k]), 64'(exp_q[k].size() != 0));
         if (yumi_i[k])
            chk("illegal_yumi", 64'(v_o[k]), 64'(1));
      end
      if (reset_i) begin
         exp_q[0].delete();
         exp_q[1].delete();
         mptr = 1'b0;
      end else if (v_i && exp_ready) begin
         exp_q[mptr].push_back(data_i);
         mptr = ~mptr;
         acc_cnt++;
      end
   end

   // Output-side monitor: every dequeue must present the oldest expected word.
   always @(negedge clk_i) begin
      #1;
      for (int k = 0; k < 2; k++) begin
         if (!reset_i && v_o[k] && yumi_i[k]) begin
            if (exp_q[k].size() == 0) begin
               chk("unexpected_pop", 64'(1), 64'(0));
            end else begin
               chk("data_o", 64'(data_o[k*W +: W]), 64'(exp_q[k].pop_front()));
            end
         end
      end
   end

   task automatic step(input logic v, input logic [W-1:0] d, input logic [1:0] y);
      v_i    = v;
      data_i = d;
      yumi_i = y;
      @(posedge clk_i);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 2*ELS + 2; i++)
         step(1'b0, '0, v_o);
   endtask

   int acc0;

   initial begin
      reset_i = 1'b1;
      v_i     = 1'b0;
      data_i  = '0;
      yumi_i  = 2'b00;
      repeat (3) @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      #1;
      chk("post_reset_ready", 64'(ready_o), 64'(1));
      chk("post_reset_tag", 64'(tag_o), 64'(0));
      chk("post_reset_v_o", 64'(v_o), 64'(0));

      // A,B,C,D back to back, consumers always draining
      for (int i = 0; i < 4; i++) begin
         chk("t1_tag", 64'(tag_o), 64'(i % 2));
         step(1'b1, W'(32'hA0 + i), v_o);
      end
      chk("t1_tag_end", 64'(tag_o), 64'(0));
      drain();

      // fill both channels with no consumers
      acc0 = acc_cnt;
      for (int i = 0; i < 2*ELS + 2; i++)
         step(1'b1, W'($urandom), 2'b00);
      chk("t2_accepted", 64'(acc_cnt - acc0), 64'(2*ELS));
      chk("t2_ready", 64'(ready_o), 64'(0));
      chk("t2_tag", 64'(tag_o), 64'(0));
      chk("t2_v_o", 64'(v_o), 64'(2'b11));

      // ch0 full, ch1 empty, pointer on ch0
      for (int i = 0; i < ELS; i++)
         step(1'b0, '0, 2'b10);
      chk("t3_v_o", 64'(v_o), 64'(2'b01));
      chk("t3_ready_blocked", 64'(ready_o), 64'(0));
      v_i    = 1'b0;
      yumi_i = 2'b01;
      #1;
      chk("t3_ready_no_comb", 64'(ready_o), 64'(0));
      @(posedge clk_i);
      #1;
      chk("t3_ready_next", 64'(ready_o), 64'(1));
      chk("t3_tag", 64'(tag_o), 64'(0));
      step(1'b1, W'(32'hC3), 2'b00);
      chk("t3_tag_after", 64'(tag_o), 64'(1));

      // same-cycle push and pop on ch0
      step(1'b1, W'(32'hD1), 2'b00);
      step(1'b0, '0, 2'b01);
      step(1'b1, W'(32'hD0), 2'b01);
      step(1'b1, W'(32'hD2), 2'b00);
      chk("t4_ready", 64'(ready_o), 64'(1));
      drain();

      // mid-stream reset discards buffered words
      for (int i = 0; i < 3; i++)
         step(1'b1, W'(32'hE0 + i), 2'b00);
      reset_i = 1'b1;
      step(1'b0, '0, 2'b00);
      reset_i = 1'b0;
      #1;
      chk("t5_v_o", 64'(v_o), 64'(0));
      chk("t5_tag", 64'(tag_o), 64'(0));
      chk("t5_ready", 64'(ready_o), 64'(1));
      for (int i = 0; i < 4; i++)
         step(1'b1, W'(32'hF0 + i), v_o);
      drain();

      // random traffic
      for (int i = 0; i < 10000; i++)
         step(($urandom_range(0, 3) != 0), W'($urandom), v_o & 2'($urandom));
      drain();
      chk("final_empty", 64'(exp_q[0].size() + exp_q[1].size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
